// File: rtl/msdap_ctrl_mc.sv
// Sequencing controller for the multi-channel MSDAP datapath: loads the Rj and
// coefficient tables, then runs the sample loop with per-channel sleep tracking.
//
// state      | meaning
// INIT       | clear all memories, ALU and back end; zero every counter
// WAIT_RJ    | wait for frame before the Rj table
// READ_RJ    | write one Rj word per word_valid
// WAIT_COEFF | wait for frame before the coefficient table
// READ_COEFF | write one coefficient word per word_valid
// WAIT_DATA  | wait for frame before samples
// WORKING    | write samples, kick the ALU, forward results
// CLEARING   | one-cycle soft clear of samples, ALU and back end
// SLEEPING   | every channel idle; samples written, ALU and back end held
module msdap_ctrl_mc #(
    parameter int NUM_CH      = 2,
    parameter int RJ_DEPTH    = 16,
    parameter int COEFF_DEPTH = 512,
    parameter int DATA_DEPTH  = 256,
    parameter int ZERO_RUN    = 800,
    localparam int RJ_AW = (RJ_DEPTH > 1) ? $clog2(RJ_DEPTH) : 1,
    localparam int CF_AW = (COEFF_DEPTH > 1) ? $clog2(COEFF_DEPTH) : 1,
    localparam int DT_AW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              frame,
    input  logic              word_valid,
    input  logic [NUM_CH-1:0] ch_zero,
    input  logic              clear_req,
    input  logic              conv_done,
    output logic              in_ready,
    output logic              rj_wr_en,
    output logic [RJ_AW-1:0]  rj_addr,
    output logic              coeff_wr_en,
    output logic [CF_AW-1:0]  coeff_addr,
    output logic              data_wr_en,
    output logic [DT_AW-1:0]  data_addr,
    output logic              mem_clear,
    output logic              data_clear,
    output logic              alu_start,
    output logic              alu_clear,
    output logic              p2s_clear,
    output logic              p2s_load,
    output logic [NUM_CH-1:0] ch_sleep,
    output logic [3:0]        state_o
);

    localparam int ZW = $clog2(ZERO_RUN + 1);

    typedef enum logic [3:0] {
        INIT       = 4'd0,
        WAIT_RJ    = 4'd1,
        READ_RJ    = 4'd2,
        WAIT_COEFF = 4'd3,
        READ_COEFF = 4'd4,
        WAIT_DATA  = 4'd5,
        WORKING    = 4'd6,
        CLEARING   = 4'd7,
        SLEEPING   = 4'd8
    } state_t;

    state_t            state, state_next;
    logic [ZW-1:0]     zero_cnt  [NUM_CH];
    logic [ZW-1:0]     zero_next [NUM_CH];
    logic [NUM_CH-1:0] sleep_next;
    logic              abort;
    logic              run_state;
    logic              clear_ok;
    logic              zr_upd;
    logic              alu_start_q;

    assign abort     = reset | start;
    assign run_state = (state == WORKING) || (state == SLEEPING);
    assign clear_ok  = clear_req && ((state == WAIT_DATA) || run_state);

    // A clear request takes the cycle: the coincident word is dropped.
    assign rj_wr_en    = (state == READ_RJ) & word_valid & ~abort;
    assign coeff_wr_en = (state == READ_COEFF) & word_valid & ~abort;
    assign data_wr_en  = run_state & word_valid & ~abort & ~clear_req;
    assign zr_upd      = data_wr_en;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            zero_next[c] = zero_cnt[c];
            if (zr_upd) begin
                if (!ch_zero[c])
                    zero_next[c] = '0;
                else if (zero_cnt[c] != ZW'(ZERO_RUN))
                    zero_next[c] = zero_cnt[c] + 1'b1;
            end
            sleep_next[c] = (zero_next[c] == ZW'(ZERO_RUN));
            ch_sleep[c]   = (zero_cnt[c] == ZW'(ZERO_RUN));
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:       state_next = WAIT_RJ;
            WAIT_RJ:    if (frame) state_next = READ_RJ;
            READ_RJ:    if (rj_wr_en && rj_addr == RJ_AW'(RJ_DEPTH - 1)) state_next = WAIT_COEFF;
            WAIT_COEFF: if (frame) state_next = READ_COEFF;
            READ_COEFF: if (coeff_wr_en && coeff_addr == CF_AW'(COEFF_DEPTH - 1)) state_next = WAIT_DATA;
            WAIT_DATA:  if (frame) state_next = WORKING;
            WORKING:    if (&sleep_next) state_next = SLEEPING;
            SLEEPING:   if (word_valid && !(&ch_zero)) state_next = WORKING;
            CLEARING:   state_next = WAIT_DATA;
            default:    state_next = INIT;
        endcase
        if (clear_ok)
            state_next = CLEARING;
    end

    always_ff @(posedge clk) begin
        if (abort) begin
            state       <= INIT;
            rj_addr     <= '0;
            coeff_addr  <= '0;
            data_addr   <= '0;
            alu_start_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++)
                zero_cnt[c] <= '0;
        end else begin
            state <= state_next;
            // The word that puts the last channel to sleep does not start the ALU.
            alu_start_q <= data_wr_en && (state_next == WORKING);

            if (state == INIT) begin
                rj_addr    <= '0;
                coeff_addr <= '0;
            end else begin
                if (rj_wr_en)
                    rj_addr <= (rj_addr == RJ_AW'(RJ_DEPTH - 1)) ? '0 : rj_addr + 1'b1;
                if (coeff_wr_en)
                    coeff_addr <= (coeff_addr == CF_AW'(COEFF_DEPTH - 1)) ? '0 : coeff_addr + 1'b1;
            end

            if (state == INIT || state == CLEARING)
                data_addr <= '0;
            else if (data_wr_en)
                data_addr <= (data_addr == DT_AW'(DATA_DEPTH - 1)) ? '0 : data_addr + 1'b1;

            for (int c = 0; c < NUM_CH; c++) begin
                if (state == INIT || state == CLEARING)
                    zero_cnt[c] <= '0;
                else
                    zero_cnt[c] <= zero_next[c];
            end
        end
    end

    assign in_ready   = (state != INIT) && (state != CLEARING);
    assign mem_clear  = (state == INIT);
    assign data_clear = (state == CLEARING);
    assign alu_clear  = (state == INIT) || (state == CLEARING);
    assign p2s_clear  = (state == INIT) || (state == CLEARING);
    assign p2s_load   = (state == WORKING) && conv_done;
    assign alu_start  = alu_start_q;
    assign state_o    = state;

endmodule

// File: tb/tb_msdap_ctrl_mc.sv
// Scoreboard bench for msdap_ctrl_mc: stimulus queues expected memory writes and
// ALU start cycles; a negedge monitor pops and compares whenever the DUT emits one.
module tb_msdap_ctrl_mc;

    localparam int NUM_CH      = 2;
    localparam int RJ_DEPTH    = 16;
    localparam int COEFF_DEPTH = 512;
    localparam int DATA_DEPTH  = 256;
    localparam int ZERO_RUN    = 8;

    logic              clk = 1'b0;
    logic              reset, start, frame, word_valid, clear_req, conv_done;
    logic [NUM_CH-1:0] ch_zero;
    logic              in_ready, rj_wr_en, coeff_wr_en, data_wr_en;
    logic [3:0]        rj_addr;
    logic [8:0]        coeff_addr;
    logic [7:0]        data_addr;
    logic              mem_clear, data_clear, alu_start, alu_clear, p2s_clear, p2s_load;
    logic [NUM_CH-1:0] ch_sleep;
    logic [3:0]        state_o;

    msdap_ctrl_mc #(
        .NUM_CH(NUM_CH), .RJ_DEPTH(RJ_DEPTH), .COEFF_DEPTH(COEFF_DEPTH),
        .DATA_DEPTH(DATA_DEPTH), .ZERO_RUN(ZERO_RUN)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .frame(frame),
        .word_valid(word_valid), .ch_zero(ch_zero), .clear_req(clear_req),
        .conv_done(conv_done), .in_ready(in_ready),
        .rj_wr_en(rj_wr_en), .rj_addr(rj_addr),
        .coeff_wr_en(coeff_wr_en), .coeff_addr(coeff_addr),
        .data_wr_en(data_wr_en), .data_addr(data_addr),
        .mem_clear(mem_clear), .data_clear(data_clear), .alu_start(alu_start),
        .alu_clear(alu_clear), .p2s_clear(p2s_clear), .p2s_load(p2s_load),
        .ch_sleep(ch_sleep), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  kind;   // 1 = Rj, 2 = coefficient, 3 = sample
        logic [15:0] addr;
    } wr_t;

    wr_t wq[$];
    int  aq[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_err = 0;
    int  ed;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        int  n;
        wr_t got;
        wr_t exp;
        n = int'(rj_wr_en) + int'(coeff_wr_en) + int'(data_wr_en);
        if (n > 0) begin
            got.kind = rj_wr_en ? 2'd1 : (coeff_wr_en ? 2'd2 : 2'd3);
            got.addr = rj_wr_en ? 16'(rj_addr) : (coeff_wr_en ? 16'(coeff_addr) : 16'(data_addr));
            chk("wr_en_onehot", n, 1);
            if (wq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: kind %0d addr %0d, required no write", got.kind, got.addr);
            end else begin
                exp = wq.pop_front();
                chk("wr_kind", int'(got.kind), int'(exp.kind));
                chk("wr_addr", int'(got.addr), int'(exp.addr));
            end
        end
        if (alu_start) begin
            if (aq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_alu_start: cycle %0d, required none", cyc);
            end else begin
                chk("alu_start_cycle", cyc, aq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame = 1'b1;
        tick();
        frame = 1'b0;
    endtask

    // kind 0 means the word must not be written anywhere.
    task automatic send_word(input logic [1:0] cz, input int kind, input int addr, input bit exp_alu);
        wr_t w;
        if (kind != 0) begin
            w.kind = 2'(kind);
            w.addr = 16'(addr);
            wq.push_back(w);
        end
        if (exp_alu) aq.push_back(cyc + 1);
        word_valid = 1'b1;
        ch_zero    = cz;
        tick();
        word_valid = 1'b0;
        ch_zero    = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; frame = 1'b0; word_valid = 1'b0;
        clear_req = 1'b0; conv_done = 1'b0; ch_zero = '0;
        tick();
        chk("rst_state", int'(state_o), 0);
        chk("rst_mem_clear", int'(mem_clear), 1);
        chk("rst_alu_clear", int'(alu_clear), 1);
        chk("rst_p2s_clear", int'(p2s_clear), 1);
        chk("rst_data_clear", int'(data_clear), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_ch_sleep", int'(ch_sleep), 0);
        chk("rst_alu_start", int'(alu_start), 0);
        reset = 1'b0;
        tick();
        chk("wait_rj_state", int'(state_o), 1);
        chk("wait_rj_in_ready", int'(in_ready), 1);

        // Words before frame are ignored.
        send_word(2'b00, 0, 0, 1'b0);
        chk("wait_rj_hold", int'(state_o), 1);
        chk("wait_rj_addr", int'(rj_addr), 0);

        pulse_frame();
        chk("read_rj_state", int'(state_o), 2);
        for (int i = 0; i < RJ_DEPTH; i++) begin
            send_word(2'b00, 1, i, 1'b0);
            if (i == 5) begin
                pulse_frame();
                chk("read_rj_frame_ignored", int'(state_o), 2);
            end
        end
        chk("rj_done_state", int'(state_o), 3);
        chk("rj_done_addr", int'(rj_addr), 0);

        pulse_frame();
        chk("read_coeff_state", int'(state_o), 4);
        for (int i = 0; i < COEFF_DEPTH; i++) send_word(2'b00, 2, i, 1'b0);
        chk("coeff_done_state", int'(state_o), 5);
        chk("coeff_done_addr", int'(coeff_addr), 0);

        pulse_frame();
        chk("working_state", int'(state_o), 6);
        for (int i = 0; i < 300; i++) send_word(2'b00, 3, i % DATA_DEPTH, 1'b1);
        chk("data_wrap_addr", int'(data_addr), 44);
        chk("working_after_300", int'(state_o), 6);
        conv_done = 1'b1;
        #1;
        chk("p2s_load_working", int'(p2s_load), 1);
        tick();
        conv_done = 1'b0;

        ed = 44;
        for (int i = 0; i < ZERO_RUN; i++) begin
            send_word(2'b01, 3, ed, 1'b1);
            ed = (ed + 1) % DATA_DEPTH;
        end
        chk("ch0_sleep_only", int'(ch_sleep), 1);
        chk("one_asleep_state", int'(state_o), 6);
        for (int i = 0; i < ZERO_RUN; i++) begin
            send_word(2'b11, 3, ed, i != ZERO_RUN - 1);
            ed = (ed + 1) % DATA_DEPTH;
        end
        chk("all_asleep_state", int'(state_o), 8);
        chk("all_asleep_flags", int'(ch_sleep), 3);
        for (int i = 0; i < 2; i++) begin
            send_word(2'b11, 3, ed, 1'b0);
            ed = (ed + 1) % DATA_DEPTH;
        end
        conv_done = 1'b1;
        #1;
        chk("p2s_load_sleeping", int'(p2s_load), 0);
        tick();
        conv_done = 1'b0;
        chk("sleep_addr_advances", int'(data_addr), ed);

        send_word(2'b10, 3, ed, 1'b1);
        ed = (ed + 1) % DATA_DEPTH;
        chk("wake_state", int'(state_o), 6);
        chk("wake_flags", int'(ch_sleep), 2);
        for (int i = 0; i < ZERO_RUN; i++) begin
            send_word(2'b11, 3, ed, i != ZERO_RUN - 1);
            ed = (ed + 1) % DATA_DEPTH;
        end
        chk("resleep_state", int'(state_o), 8);

        // Clear request collides with a word: the word is dropped.
        clear_req  = 1'b1;
        word_valid = 1'b1;
        ch_zero    = 2'b11;
        #1;
        chk("clear_no_write", int'(data_wr_en), 0);
        tick();
        clear_req = 1'b0; word_valid = 1'b0; ch_zero = '0;
        chk("clearing_state", int'(state_o), 7);
        chk("clearing_data_clear", int'(data_clear), 1);
        chk("clearing_mem_clear", int'(mem_clear), 0);
        chk("clearing_alu_clear", int'(alu_clear), 1);
        chk("clearing_in_ready", int'(in_ready), 0);
        tick();
        chk("after_clear_state", int'(state_o), 5);
        chk("after_clear_addr", int'(data_addr), 0);
        chk("after_clear_sleep", int'(ch_sleep), 0);

        pulse_frame();
        chk("rework_state", int'(state_o), 6);
        send_word(2'b00, 3, 0, 1'b1);
        send_word(2'b00, 3, 1, 1'b1);
        chk("rework_addr", int'(data_addr), 2);

        // Reset beats a simultaneous clear request.
        reset = 1'b1;
        clear_req = 1'b1;
        tick();
        reset = 1'b0;
        clear_req = 1'b0;
        chk("rst_vs_clear_state", int'(state_o), 0);
        chk("rst_vs_clear_mem_clear", int'(mem_clear), 1);
        chk("rst_vs_clear_data_addr", int'(data_addr), 0);
        tick();
        chk("rst_vs_clear_next", int'(state_o), 1);

        pulse_frame();
        for (int i = 0; i < RJ_DEPTH; i++) send_word(2'b00, 1, i, 1'b0);
        pulse_frame();
        for (int i = 0; i < 100; i++) send_word(2'b00, 2, i, 1'b0);
        chk("mid_coeff_addr", int'(coeff_addr), 100);
        chk("mid_coeff_state", int'(state_o), 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_state", int'(state_o), 0);
        chk("start_mem_clear", int'(mem_clear), 1);
        chk("start_coeff_addr", int'(coeff_addr), 0);
        tick();
        chk("start_next_state", int'(state_o), 1);
        chk("start_next_coeff_addr", int'(coeff_addr), 0);

        repeat (3) tick();
        chk("writes_outstanding", wq.size(), 0);
        chk("alu_starts_outstanding", aq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
